// File: rtl/dht11_responder.sv
// Sensor-side DHT11 single-wire responder: waits for a host start pulse, then sends
// the 80/80 acknowledge, 40 data bits (MSB first) and the end-of-frame low.
//
// state    | meaning
// IDLE     | watching line_s for a long host low followed by release
// WAIT     | line released, pause before acknowledge
// ACK_LOW  | acknowledge, line driven low
// ACK_HIGH | acknowledge, line released
// BIT_L    | low preamble of data bit bit_idx
// BIT_H    | released time encoding frame[bit_idx]
// END_L    | end-of-frame low, then back to IDLE
module dht11_responder #(
  parameter int MIN_START_LOW = 18000,
  parameter int RESP_WAIT     = 30,
  parameter int RESP_LOW      = 80,
  parameter int RESP_HIGH     = 80,
  parameter int BIT_LOW       = 50,
  parameter int BIT0_HIGH     = 26,
  parameter int BIT1_HIGH     = 70
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        dht_data,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  output logic       busy,
  output logic       frame_done
);

  localparam int LW = $clog2(MIN_START_LOW + 1);
  localparam int PW = $clog2(RESP_WAIT + RESP_LOW + RESP_HIGH + BIT_LOW + BIT0_HIGH + BIT1_HIGH + 1);
  localparam logic [LW-1:0] LOW_MAX = LW'(MIN_START_LOW);

  typedef enum logic [2:0] {
    IDLE, WAIT, ACK_LOW, ACK_HIGH, BIT_L, BIT_H, END_L
  } state_t;

  state_t          state, state_next;
  logic            line_m, line_s;
  logic            armed;
  logic [LW-1:0]   low_cnt;
  logic [PW-1:0]   phase_cnt;
  logic [PW-1:0]   phase_len;
  logic            phase_end;
  logic [5:0]      bit_idx;
  logic [39:0]     frame;
  logic [7:0]      chk;
  logic            drive_low;
  logic            start_det;

  assign dht_data = drive_low ? 1'b0 : 1'bz;

  assign chk = hum_int + hum_dec + temp_int + temp_dec;

  // low_cnt is cleared whenever line_s is high, so reaching the maximum while
  // line_s is high can only mean a qualifying low has just been released.
  assign start_det = (state == IDLE) && armed && line_s && (low_cnt == LOW_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_m <= 1'b0;
      line_s <= 1'b0;
    end else begin
      line_m <= dht_data;
      line_s <= line_m;
    end
  end

  always_comb begin
    phase_len = '0;
    case (state)
      WAIT:         phase_len = PW'(RESP_WAIT);
      ACK_LOW:      phase_len = PW'(RESP_LOW);
      ACK_HIGH:     phase_len = PW'(RESP_HIGH);
      BIT_L, END_L: phase_len = PW'(BIT_LOW);
      BIT_H:        phase_len = frame[bit_idx] ? PW'(BIT1_HIGH) : PW'(BIT0_HIGH);
      default:      phase_len = '0;
    endcase
  end

  assign phase_end = (state != IDLE) && (phase_cnt == phase_len - 1'b1);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start_det) state_next = WAIT;
      WAIT:     if (phase_end) state_next = ACK_LOW;
      ACK_LOW:  if (phase_end) state_next = ACK_HIGH;
      ACK_HIGH: if (phase_end) state_next = BIT_L;
      BIT_L:    if (phase_end) state_next = BIT_H;
      BIT_H:    if (phase_end) state_next = (bit_idx == 6'd0) ? END_L : BIT_L;
      END_L:    if (phase_end) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      drive_low  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      armed      <= 1'b0;
      low_cnt    <= '0;
      phase_cnt  <= '0;
      bit_idx    <= '0;
      frame      <= '0;
    end else begin
      state      <= state_next;
      drive_low  <= (state_next == ACK_LOW) || (state_next == BIT_L) || (state_next == END_L);
      busy       <= (state_next != IDLE);
      frame_done <= (state == END_L) && phase_end;

      if ((state_next != state) || (state == IDLE))
        phase_cnt <= '0;
      else
        phase_cnt <= phase_cnt + 1'b1;

      // A low still present when the frame ends must see a release before it can count.
      if ((state == END_L) && phase_end)
        armed <= 1'b0;
      else if ((state == IDLE) && line_s)
        armed <= 1'b1;

      if ((state != IDLE) || line_s || !armed)
        low_cnt <= '0;
      else if (low_cnt != LOW_MAX)
        low_cnt <= low_cnt + 1'b1;

      if (start_det)
        frame <= {hum_int, hum_dec, temp_int, temp_dec, chk};

      if ((state == ACK_HIGH) && phase_end)
        bit_idx <= 6'd39;
      else if ((state == BIT_H) && phase_end && (bit_idx != 6'd0))
        bit_idx <= bit_idx - 6'd1;
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Randomized scoreboard bench for dht11_responder: the host side issues start pulses and
// queues the expected frame; a line monitor decodes every frame and checks it against the queue.
module tb_dht11_responder;

  localparam int MIN_LOW   = 2000;
  localparam int RESP_WAIT = 30;
  localparam int RESP_LOW  = 80;
  localparam int RESP_HIGH = 80;
  localparam int BIT_LOW   = 50;
  localparam int BIT0_HIGH = 26;
  localparam int BIT1_HIGH = 70;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_low = 1'b0;
  logic [7:0] hum_int = '0, hum_dec = '0, temp_int = '0, temp_dec = '0;
  logic       busy, frame_done;
  wire        dht_data;

  pullup (dht_data);
  assign dht_data = host_low ? 1'b0 : 1'bz;

  dht11_responder #(
    .MIN_START_LOW(MIN_LOW), .RESP_WAIT(RESP_WAIT), .RESP_LOW(RESP_LOW), .RESP_HIGH(RESP_HIGH),
    .BIT_LOW(BIT_LOW), .BIT0_HIGH(BIT0_HIGH), .BIT1_HIGH(BIT1_HIGH)
  ) dut (
    .clk(clk), .rst(rst), .dht_data(dht_data),
    .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [39:0] exp_q[$];
  int run_code[$];
  int run_len[$];
  int cur_code = -1;
  int cur_len  = 0;
  int done_cnt = 0;
  int busy_bad = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] model_frame(input logic [7:0] a, b, c, d);
    int s;
    s = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
    return {a, b, c, d, 8'(s)};
  endfunction

  // Expected line shape: release after start, ack 80/80, 40 x (50 low, 26/70 high), 50 low.
  task automatic check_frame();
    logic [39:0] exp, got;
    int base, bad;
    check("frame_expected", exp_q.size() > 0, 1);
    if (exp_q.size() == 0) return;
    exp = exp_q.pop_front();
    check("frame_run_count", run_len.size() >= 85, 1);
    if (run_len.size() < 85) return;
    base = run_len.size() - 84;
    check("start_by_host", run_code[base-1], 2);
    check("wait_len", run_len[base], RESP_WAIT + 3);
    check("ack_low_len", run_len[base+1], RESP_LOW);
    check("ack_high_len", run_len[base+2], RESP_HIGH);
    bad = 0;
    got = '0;
    for (int j = 0; j < 40; j++) begin
      int lo, hi;
      lo = run_len[base + 3 + 2*j];
      hi = run_len[base + 4 + 2*j];
      if (lo != BIT_LOW) bad++;
      if (hi == BIT1_HIGH) got = {got[38:0], 1'b1};
      else if (hi == BIT0_HIGH) got = {got[38:0], 1'b0};
      else begin bad++; got = {got[38:0], 1'b0}; end
    end
    check("bit_timing_errors", bad, 0);
    check("frame_bits", got, exp);
    check("end_low_len", run_len[base+83], BIT_LOW);
    check("busy_while_driving", busy_bad, 0);
    busy_bad = 0;
    run_code.delete();
    run_len.delete();
  endtask

  // Line monitor: 1 = responder driving low, 2 = host start low, 0 = released.
  always @(negedge clk) begin
    int c;
    if (rst) begin
      run_code.delete();
      run_len.delete();
      cur_code = -1;
      cur_len  = 0;
      busy_bad = 0;
      prev_done = 1'b0;
    end else begin
      if (host_low) c = dut.drive_low ? 1 : (busy ? 0 : 2);
      else c = (dht_data === 1'b0) ? 1 : 0;
      if (c == 1 && !busy) busy_bad++;
      if (c == cur_code) cur_len++;
      else begin
        if (cur_code >= 0) begin
          run_code.push_back(cur_code);
          run_len.push_back(cur_len);
        end
        cur_code = c;
        cur_len  = 1;
      end
      if (prev_done) check("done_pulse_width", frame_done, 0);
      if (frame_done) begin
        done_cnt++;
        check("busy_at_done", busy, 0);
        check_frame();
      end
      prev_done = frame_done;
    end
  end

  task automatic host_start(input int len, input bit expect_frame);
    @(posedge clk); #1 host_low = 1'b1;
    repeat (len) @(posedge clk);
    #1 host_low = 1'b0;
    if (expect_frame) exp_q.push_back(model_frame(hum_int, hum_dec, temp_int, temp_dec));
  endtask

  task automatic wait_done(input string name);
    int start;
    start = done_cnt;
    for (int i = 0; i < 8000 && done_cnt == start; i++) @(negedge clk);
    @(negedge clk);
    check(name, done_cnt > start, 1);
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (busy || frame_done || (dht_data === 1'b0 && !host_low)) hits++;
    end
    check(name, hits, 0);
  endtask

  task automatic set_payload(input logic [7:0] a, b, c, d);
    hum_int = a; hum_dec = b; temp_int = c; temp_dec = d;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] f;
    int s;
    repeat (4) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_line", dht_data, 1);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    set_payload(8'h37, 8'h00, 8'h19, 8'h05);
    host_start(MIN_LOW, 1'b1);
    wait_done("frame1_timeout");
    repeat (20) @(posedge clk);

    host_start(MIN_LOW - 1, 1'b0);
    watch_quiet("short_low_ignored", 300);

    // All-ones payload, cleared just after the start is taken, plus host noise in the ack.
    set_payload(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    host_start(MIN_LOW, 1'b1);
    repeat (3) @(posedge clk);
    #1 set_payload(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (117) @(posedge clk);
    #1 host_low = 1'b1;
    repeat (100) @(posedge clk);
    #1 host_low = 1'b0;
    wait_done("frame_ff_timeout");
    watch_quiet("no_second_frame", 300);

    set_payload(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    f = model_frame(hum_int, hum_dec, temp_int, temp_dec);
    host_start(MIN_LOW, 1'b1);
    s = 0;
    for (int j = 0; j < 19; j++) s += BIT_LOW + (f[39-j] ? BIT1_HIGH : BIT0_HIGH);
    repeat (253 + s) @(posedge clk);
    #1 check("busy_before_reset", busy, 1);
    rst = 1'b1;
    void'(exp_q.pop_back());
    #1;
    check("reset_mid_line", dht_data, 1);
    check("reset_mid_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    watch_quiet("aborted_frame_silent", 200);

    for (int k = 0; k < 3; k++) begin
      set_payload(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      host_start(MIN_LOW + $urandom_range(40, 0), 1'b1);
      if ($urandom_range(1, 0) == 1) begin
        repeat (5) @(posedge clk);
        #1 set_payload(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end
      wait_done("frame_rand_timeout");
      repeat ($urandom_range(30, 5)) @(posedge clk);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
